// File: rtl/charobj_pkg.sv
// Shared widths, field offsets, FSM encoding and word-packing helpers for the
// character-object RAM responder.
package charobj_pkg;

   localparam int unsigned CHAROBJ_X_W    = 10;
   localparam int unsigned CHAROBJ_Y_W    = 10;
   localparam int unsigned CHAROBJ_IDX_W  = 8;
   localparam int unsigned CHAROBJ_WORD_W = 28;

   localparam int unsigned CHAROBJ_X_OFS   = 18;
   localparam int unsigned CHAROBJ_Y_OFS   = 8;
   localparam int unsigned CHAROBJ_IDX_OFS = 0;

   localparam logic [CHAROBJ_IDX_W-1:0] CHAROBJ_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDone  = 2'd2
   } charobj_state_t;

   function automatic logic [CHAROBJ_WORD_W-1:0] charobj_pack(
      input logic [CHAROBJ_X_W-1:0]   x,
      input logic [CHAROBJ_Y_W-1:0]   y,
      input logic [CHAROBJ_IDX_W-1:0] idx
   );
      return {x, y, idx};
   endfunction

endpackage

// File: rtl/charobj_dp_ram.sv
// Simple dual-port DEPTH x 28 store: one write port, one synchronous read-first
// read port; written to infer block RAM.
module charobj_dp_ram
   import charobj_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                      clk_calculation,
   input  logic                      i_wr_en,
   input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
   input  logic [CHAROBJ_WORD_W-1:0] i_wr_data,
   input  logic                      i_rd_en,
   input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
   output logic [CHAROBJ_WORD_W-1:0] o_rd_data
);

   logic [CHAROBJ_WORD_W-1:0] r_mem [DEPTH];
   logic [CHAROBJ_WORD_W-1:0] r_rd_data;

   // Non-blocking write and read in one block give read-first on collision.
   always_ff @(posedge clk_calculation) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/character_object_ram_responder.sv
// Writable character-object store answering the addr/sync/update fetch handshake.
// Optional CHAROBJ_WRITE_BYPASS_EN forwards a same-edge write into the response.
module character_object_ram_responder
   import charobj_pkg::*;
#(
   parameter int unsigned     ADDR_WIDTH  = 10,
   parameter int unsigned     DEPTH       = 1024,
   parameter logic [7:0]      BLANK_INDEX = CHAROBJ_BLANK
) (
   input  logic                     clk_calculation,
   input  logic                     reset,
   input  logic [ADDR_WIDTH-1:0]    addr,
   input  logic                     sync_character,
   output logic                     update_character,
   output logic [CHAROBJ_X_W-1:0]   character_pos_x,
   output logic [CHAROBJ_Y_W-1:0]   character_pos_y,
   output logic [CHAROBJ_IDX_W-1:0] character_index,
   input  logic                     wr_en,
   input  logic [ADDR_WIDTH-1:0]    wr_addr,
   input  logic [CHAROBJ_X_W-1:0]   wr_pos_x,
   input  logic [CHAROBJ_Y_W-1:0]   wr_pos_y,
   input  logic [CHAROBJ_IDX_W-1:0] wr_index,
   output logic [ADDR_WIDTH:0]      entry_count,
   input  logic                     clear
);

   localparam int unsigned       RamAw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DepthL = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] OneL   = 1;

   charobj_state_t              r_state;
   logic                        r_update;
   logic                        r_req_oob;
   logic [CHAROBJ_X_W-1:0]      r_pos_x;
   logic [CHAROBJ_Y_W-1:0]      r_pos_y;
   logic [CHAROBJ_IDX_W-1:0]    r_index;
   logic [ADDR_WIDTH:0]         r_entry_count;

   logic                        w_wr_ok;
   logic                        w_rd_issue;
   logic                        w_rd_oob;
   logic [ADDR_WIDTH:0]         w_wr_next;
   logic [CHAROBJ_WORD_W-1:0]   w_wr_word;
   logic [CHAROBJ_WORD_W-1:0]   w_ram_word;
   logic [CHAROBJ_WORD_W-1:0]   w_rsp_word;

   assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < DepthL);
   assign w_rd_issue = (r_state == StIdle) && !sync_character;
   assign w_rd_oob   = ({1'b0, addr} >= DepthL);
   assign w_wr_next  = {1'b0, wr_addr} + OneL;
   assign w_wr_word  = charobj_pack(wr_pos_x, wr_pos_y, wr_index);

   charobj_dp_ram #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (RamAw)
   ) u_ram (
      .clk_calculation (clk_calculation),
      .i_wr_en         (w_wr_ok),
      .i_wr_addr       (wr_addr[RamAw-1:0]),
      .i_wr_data       (w_wr_word),
      .i_rd_en         (w_rd_issue),
      .i_rd_addr       (addr[RamAw-1:0]),
      .o_rd_data       (w_ram_word)
   );

`ifdef CHAROBJ_WRITE_BYPASS_EN
   logic                      r_byp_hit;
   logic [CHAROBJ_WORD_W-1:0] r_byp_word;

   // Capture a write that collides with the read on the read-issue edge.
   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         r_byp_hit  <= 1'b0;
         r_byp_word <= '0;
      end else if (w_rd_issue) begin
         r_byp_hit  <= w_wr_ok && (wr_addr == addr);
         r_byp_word <= w_wr_word;
      end
   end

   assign w_rsp_word = r_byp_hit ? r_byp_word : w_ram_word;
`else
   assign w_rsp_word = w_ram_word;
`endif

   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         r_state   <= StIdle;
         r_update  <= 1'b0;
         r_req_oob <= 1'b0;
         r_pos_x   <= '0;
         r_pos_y   <= '0;
         r_index   <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               r_update <= 1'b0;
               if (!sync_character) begin
                  r_req_oob <= w_rd_oob;
                  r_state   <= StFetch;
               end
            end
            StFetch: begin
               if (r_req_oob) begin
                  r_pos_x <= '0;
                  r_pos_y <= '0;
                  r_index <= BLANK_INDEX;
               end else begin
                  r_pos_x <= w_rsp_word[CHAROBJ_X_OFS +: CHAROBJ_X_W];
                  r_pos_y <= w_rsp_word[CHAROBJ_Y_OFS +: CHAROBJ_Y_W];
                  r_index <= w_rsp_word[CHAROBJ_IDX_OFS +: CHAROBJ_IDX_W];
               end
               r_update <= 1'b1;
               r_state  <= StDone;
            end
            StDone: begin
               if (sync_character) begin
                  r_update <= 1'b0;
                  r_state  <= StIdle;
               end
            end
            default: begin
               r_update <= 1'b0;
               r_state  <= StIdle;
            end
         endcase
      end
   end

   // clear wins over the count update; the RAM write itself still happens.
   always_ff @(posedge clk_calculation) begin
      if (reset || clear) begin
         r_entry_count <= '0;
      end else if (w_wr_ok && (w_wr_next > r_entry_count)) begin
         r_entry_count <= w_wr_next;
      end
   end

   assign update_character = r_update;
   assign character_pos_x  = r_pos_x;
   assign character_pos_y  = r_pos_y;
   assign character_index  = r_index;
   assign entry_count      = r_entry_count;

endmodule

// File: tb/tb_character_object_ram_responder.sv
// Directed self-checking bench for character_object_ram_responder (DEPTH=512).
module tb_character_object_ram_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 512;

   logic          clk_calculation;
   logic          reset;
   logic [AW-1:0] addr;
   logic          sync_character;
   logic          update_character;
   logic [9:0]    character_pos_x;
   logic [9:0]    character_pos_y;
   logic [7:0]    character_index;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [9:0]    wr_pos_x;
   logic [9:0]    wr_pos_y;
   logic [7:0]    wr_index;
   logic [AW:0]   entry_count;
   logic          clear;

   int checks;
   int errors;
   int collide_idx;

   character_object_ram_responder #(
      .ADDR_WIDTH  (AW),
      .DEPTH       (DEPTH),
      .BLANK_INDEX (8'hFF)
   ) dut (
      .clk_calculation  (clk_calculation),
      .reset            (reset),
      .addr             (addr),
      .sync_character   (sync_character),
      .update_character (update_character),
      .character_pos_x  (character_pos_x),
      .character_pos_y  (character_pos_y),
      .character_index  (character_index),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_pos_x         (wr_pos_x),
      .wr_pos_y         (wr_pos_y),
      .wr_index         (wr_index),
      .entry_count      (entry_count),
      .clear            (clear)
   );

   initial clk_calculation = 1'b0;
   always #5 clk_calculation = ~clk_calculation;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; leave time at 1 unit past it for sampling and driving.
   task automatic tick();
      @(posedge clk_calculation);
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [9:0] x,
                             input logic [9:0] y, input logic [7:0] idx);
      wr_en    = 1'b1;
      wr_addr  = a;
      wr_pos_x = x;
      wr_pos_y = y;
      wr_index = idx;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic check_fields(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic [7:0] idx);
      check_val({tag, "_x"},   32'(character_pos_x), 32'(x));
      check_val({tag, "_y"},   32'(character_pos_y), 32'(y));
      check_val({tag, "_idx"}, 32'(character_index), 32'(idx));
   endtask

   initial begin
      checks = 0;
      errors = 0;
`ifdef CHAROBJ_WRITE_BYPASS_EN
      collide_idx = 7;
`else
      collide_idx = 2;
`endif
      reset = 1'b1; sync_character = 1'b1; addr = '0; clear = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_pos_x = '0; wr_pos_y = '0; wr_index = '0;
      tick();
      tick();
      reset = 1'b0;
      check_val("rst_update", 32'(update_character), 32'd0);
      check_fields("rst", 10'd0, 10'd0, 8'd0);
      check_val("rst_count", 32'(entry_count), 32'd0);

      // 1: basic fetch of addr 3
      write_word(10'd3, 10'd100, 10'd200, 8'd26);
      check_val("t1_count", 32'(entry_count), 32'd4);
      addr = 10'd3; sync_character = 1'b0;
      tick();
      check_val("t1_upd_e0", 32'(update_character), 32'd0);
      tick();
      check_val("t1_upd_e1", 32'(update_character), 32'd1);
      check_fields("t1", 10'd100, 10'd200, 8'd26);
      sync_character = 1'b1;
      tick();
      check_val("t1_upd_rel", 32'(update_character), 32'd0);
      check_fields("t1_idle", 10'd100, 10'd200, 8'd26);

      // 2: hold in DONE, addr wiggles must be ignored
      write_word(10'd7, 10'd1, 10'd2, 8'd3);
      addr = 10'd3; sync_character = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         addr = (i % 2 == 0) ? 10'd7 : 10'd3;
         tick();
         check_val("t2_hold_upd", 32'(update_character), 32'd1);
         check_val("t2_hold_idx", 32'(character_index), 32'd26);
      end
      sync_character = 1'b1;
      tick();

      // 3: out-of-range read returns blank
      addr = 10'd1023; sync_character = 1'b0;
      tick();
      check_val("t3_upd_e0", 32'(update_character), 32'd0);
      tick();
      check_val("t3_upd_e1", 32'(update_character), 32'd1);
      check_fields("t3", 10'd0, 10'd0, 8'hFF);
      sync_character = 1'b1;
      tick();

      // 4: write/read collision on addr 5
      write_word(10'd5, 10'd1, 10'd1, 8'd2);
      addr = 10'd5; sync_character = 1'b0;
      wr_en = 1'b1; wr_addr = 10'd5; wr_pos_x = 10'd11; wr_pos_y = 10'd12; wr_index = 8'd7;
      tick();
      wr_en = 1'b0;
      tick();
      check_val("t4_collide_idx", 32'(character_index), 32'(collide_idx));
      sync_character = 1'b1;
      tick();
      sync_character = 1'b0;
      tick();
      tick();
      check_fields("t4_new", 10'd11, 10'd12, 8'd7);
      sync_character = 1'b1;
      tick();

      // 5: entry_count tracking, clear priority, dropped out-of-range write
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_val("t5_clear0", 32'(entry_count), 32'd0);
      write_word(10'd4, 10'd0, 10'd0, 8'd4);
      write_word(10'd9, 10'd0, 10'd0, 8'd9);
      write_word(10'd2, 10'd0, 10'd0, 8'd2);
      check_val("t5_count10", 32'(entry_count), 32'd10);
      clear = 1'b1;
      write_word(10'd1, 10'd33, 10'd44, 8'd55);
      clear = 1'b0;
      check_val("t5_clear_wr", 32'(entry_count), 32'd0);
      write_word(10'd600, 10'd9, 10'd9, 8'd9);
      check_val("t5_oob_wr", 32'(entry_count), 32'd0);
      addr = 10'd1; sync_character = 1'b0;
      tick();
      tick();
      check_fields("t5_rd1", 10'd33, 10'd44, 8'd55);

      // 6: reset during DONE with sync still low
      reset = 1'b1;
      tick();
      check_val("t6_rst_upd", 32'(update_character), 32'd0);
      check_fields("t6_rst", 10'd0, 10'd0, 8'd0);
      reset = 1'b0;
      tick();
      check_val("t6_upd_e0", 32'(update_character), 32'd0);
      tick();
      check_val("t6_upd_e1", 32'(update_character), 32'd1);
      check_fields("t6", 10'd33, 10'd44, 8'd55);
      sync_character = 1'b1;
      tick();
      check_val("t6_upd_rel", 32'(update_character), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
